// File: rtl/note_pkg.sv
// Shared definitions for the tone detector: note codes, nominal half-periods
// in 25 MHz cycles, classification bin edges and the spacing classifier.
package note_pkg;

  localparam int CW_DEF = 17;

  typedef logic [3:0] note_t;

  localparam note_t NOTE_NONE = 4'd0;
  localparam note_t NOTE_DO   = 4'd1;
  localparam note_t NOTE_RE   = 4'd2;
  localparam note_t NOTE_MI   = 4'd3;
  localparam note_t NOTE_FA   = 4'd4;
  localparam note_t NOTE_SOL  = 4'd5;
  localparam note_t NOTE_LA   = 4'd6;
  localparam note_t NOTE_SI   = 4'd7;
  localparam note_t NOTE_DO2  = 4'd8;

  // Nominal half-periods of the scale notes
  localparam int HP_DO  = 47709;
  localparam int HP_RE  = 42517;
  localparam int HP_MI  = 37878;
  localparam int HP_FA  = 35816;
  localparam int HP_SOL = 31887;
  localparam int HP_LA  = 28409;
  localparam int HP_SI  = 25303;
  localparam int HP_DO2 = 23900;

  // Bin edges: outer limits and the midpoints between neighbouring notes
  localparam int HP_MAX    = 50094;
  localparam int HP_DO_RE  = 45113;
  localparam int HP_RE_MI  = 40197;
  localparam int HP_MI_FA  = 36847;
  localparam int HP_FA_SOL = 33851;
  localparam int HP_SOL_LA = 30148;
  localparam int HP_LA_SI  = 26856;
  localparam int HP_SI_DO2 = 24601;
  localparam int HP_MIN    = 22705;

  typedef logic [CW_DEF-1:0] hp_t;

  // Index 0 is the upper limit of do, index i (1..7) the lower (exclusive)
  // edge of note i, index 8 the inclusive lower limit of do2.
  typedef hp_t [8:0] hp_bounds_t;

  localparam hp_bounds_t HP_BOUNDS_DEF = {
    hp_t'(HP_MIN),    hp_t'(HP_SI_DO2), hp_t'(HP_LA_SI),  hp_t'(HP_SOL_LA),
    hp_t'(HP_FA_SOL), hp_t'(HP_MI_FA),  hp_t'(HP_RE_MI),  hp_t'(HP_DO_RE),
    hp_t'(HP_MAX)
  };

  typedef enum logic [1:0] {
    ST_SILENT  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Map a measured spacing onto a note code; anything outside the scale is NONE
  function automatic note_t classify(input hp_t s, input hp_bounds_t b);
    note_t c;
    c = NOTE_NONE;
    if (s >= b[8] && s <= b[0]) begin
      c = NOTE_DO2;
      // Walk from high notes to low so the lowest satisfied edge wins
      for (int i = 7; i >= 1; i--) begin
        if (s > b[i]) c = note_t'(i);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Tone period meter: synchronises the tone input, detects every toggle and
// measures the spacing between toggles with a saturating counter.
module tone_period_meter #(
  parameter int CW      = 17,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tone_in,
  input  logic          enable,
  output logic          meas_valid_o,
  output logic [CW-1:0] meas_o,
  output logic          timeout_o
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic          prev_q;
  logic          toggle;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          discard_q;
  logic          meas_valid_q;
  logic [CW-1:0] meas_q;

  // A toggle in either direction marks an edge cycle
  assign toggle = sync2_q ^ prev_q;

  // Fires once, in the cycle the counter is about to hit its ceiling; an edge in
  // that cycle takes precedence and is measured as an out-of-range spacing.
  assign timeout_o = enable & ~toggle & (cnt_q == CNT_LAST);

  // Next counter value: cleared when disabled, restarted by an edge, else saturating count
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (toggle) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Two-flop synchroniser plus one flop of history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Spacing counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Capture the spacing at an edge; the first edge after silence only starts timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard_q    <= 1'b1;
      meas_valid_q <= 1'b0;
      meas_q       <= '0;
    end else begin
      meas_valid_q <= 1'b0;
      if (!enable || timeout_o) begin
        discard_q <= 1'b1;
      end else if (toggle) begin
        if (!discard_q) begin
          meas_valid_q <= 1'b1;
          meas_q       <= cnt_q;
        end
        discard_q <= 1'b0;
      end
    end
  end

  assign meas_valid_o = meas_valid_q;
  assign meas_o       = meas_q;

endmodule

// File: rtl/tone_detector.sv
// Tone detector top: classifies each measured half-period into a scale note
// and publishes the note once it has been seen STABLE_CNT times in a row.
module tone_detector
  import note_pkg::*;
#(
  parameter int         STABLE_CNT = 4,
  parameter int         TIMEOUT    = 65535,
  parameter int         CW         = CW_DEF,
  parameter hp_bounds_t HP_BOUNDS  = HP_BOUNDS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tone_in,
  input  logic          enable,
  output logic [3:0]    note_id,
  output logic          note_valid,
  output logic          note_change,
  output logic [CW-1:0] half_period
);

  localparam logic [3:0] MATCH_LAST = 4'(STABLE_CNT - 1);

  logic          meas_valid;
  logic [CW-1:0] meas;
  logic          timeout;
  note_t         cls;

  state_t        state_q;
  note_t         note_q;
  note_t         cand_q;
  logic [3:0]    match_q;
  logic          change_q;

  tone_period_meter #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_meter (
    .clk          (clk),
    .rst          (rst),
    .tone_in      (tone_in),
    .enable       (enable),
    .meas_valid_o (meas_valid),
    .meas_o       (meas),
    .timeout_o    (timeout)
  );

  assign cls = classify(hp_t'(meas), HP_BOUNDS);

  // Note acquisition FSM with registered note and change pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SILENT;
      note_q   <= NOTE_NONE;
      cand_q   <= NOTE_NONE;
      match_q  <= '0;
      change_q <= 1'b0;
    end else begin
      change_q <= 1'b0;
      if (!enable || timeout) begin
        state_q  <= ST_SILENT;
        note_q   <= NOTE_NONE;
        cand_q   <= NOTE_NONE;
        match_q  <= '0;
        change_q <= (note_q != NOTE_NONE);
      end else if (meas_valid) begin
        case (state_q)
          ST_SILENT: begin
            cand_q  <= cls;
            match_q <= 4'd1;
            state_q <= ST_ACQUIRE;
          end
          ST_ACQUIRE: begin
            if (cls != cand_q) begin
              cand_q  <= cls;
              match_q <= 4'd1;
            end else if (match_q == MATCH_LAST) begin
              // A run of NONE settles back to silence rather than locking
              note_q   <= cand_q;
              change_q <= (cand_q != note_q);
              match_q  <= '0;
              state_q  <= (cand_q != NOTE_NONE) ? ST_LOCKED : ST_SILENT;
            end else begin
              match_q <= match_q + 4'd1;
            end
          end
          ST_LOCKED: begin
            // The locked note stays on the output until a new lock replaces it
            if (cls != note_q) begin
              cand_q  <= cls;
              match_q <= 4'd1;
              state_q <= ST_ACQUIRE;
            end
          end
          default: begin
            state_q <= ST_SILENT;
          end
        endcase
      end
    end
  end

  assign note_id     = note_q;
  assign note_valid  = (note_q != NOTE_NONE);
  assign note_change = change_q;
  assign half_period = meas;

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector, run with the bin edges and timeout scaled down by
// about 128 so a full lock takes a few thousand cycles. An edge-level model
// tracks the published note; outputs are compared every cycle.
module tb_tone_detector;

  localparam int STABLE = 4;
  localparam int TMO    = 511;
  localparam int CW     = 17;
  localparam int HPMIN  = 177;

  // {min, si/do2, la/si, sol/la, fa/sol, mi/fa, re/mi, do/re, max}
  localparam logic [8:0][16:0] BOUNDS = {
    17'd177, 17'd192, 17'd210, 17'd235, 17'd264,
    17'd288, 17'd314, 17'd352, 17'd391
  };

  // Inclusive upper limit of each note's bin, and a nominal spacing inside it
  int upper   [1:8] = '{391, 352, 314, 288, 264, 235, 210, 192};
  int nominal [1:8] = '{373, 332, 296, 280, 249, 222, 198, 187};

  logic          clk = 1'b0;
  logic          rst;
  logic          tone_in;
  logic          enable;
  logic [3:0]    note_id;
  logic          note_valid;
  logic          note_change;
  logic [CW-1:0] half_period;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int m_note;      // note the detector has decided on
  int m_shown;     // note currently expected on the output pins
  int m_hunt;      // a run of disagreeing classifications is in progress
  int s_val;
  int s_len;
  int m_disc;      // next edge only restarts timing
  int m_hp;
  int m_hp_shown;
  int pend;        // an edge's outcome is still travelling through the pipeline
  int since;       // clock edges since the last tone toggle
  int armed;       // counter is running from a toggle, so a timeout is predictable
  int force_silent;
  int last_sp;

  always #20 clk = ~clk;

  tone_detector #(
    .STABLE_CNT (STABLE),
    .TIMEOUT    (TMO),
    .CW         (CW),
    .HP_BOUNDS  (BOUNDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tone_in     (tone_in),
    .enable      (enable),
    .note_id     (note_id),
    .note_valid  (note_valid),
    .note_change (note_change),
    .half_period (half_period)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Note for a spacing: the number of bins whose upper limit still covers it
  function automatic int ref_class(input int s);
    int c;
    c = 0;
    if (s >= HPMIN && s <= upper[1]) begin
      for (int k = 1; k <= 8; k++) if (upper[k] >= s) c++;
    end
    return c;
  endfunction

  task automatic go_silent();
    m_note = 0;
    m_hunt = 0;
    m_disc = 1;
  endtask

  // The note changes to v once STABLE consecutive measurements, counted from the
  // first one that disagrees with the current note, all classify as v.
  task automatic model_edge(input int sp);
    int c;
    last_sp = sp;
    if (m_disc != 0) begin
      m_disc = 0;
    end else begin
      c = ref_class(sp);
      m_hp = sp;
      if (m_hunt == 0) begin
        if (c != m_note) begin
          m_hunt = 1;
          s_val  = c;
          s_len  = 1;
        end
      end else begin
        if (c == s_val) s_len++;
        else begin
          s_val = c;
          s_len = 1;
        end
        if (s_len == STABLE) begin
          m_note = s_val;
          m_hunt = 0;
        end
      end
    end
    pend = 1;
  endtask

  task automatic wait_cycles(input int m);
    int exp_chg;
    repeat (m) begin
      @(posedge clk);
      #1;
      since++;
      exp_chg = 0;
      if (since == 3) m_hp_shown = m_hp;
      if (force_silent != 0) begin
        force_silent = 0;
        if (m_shown != 0) exp_chg = 1;
        m_shown = 0;
      end
      if (pend != 0 && since == 4) begin
        pend = 0;
        if (m_shown != m_note) exp_chg = 1;
        m_shown = m_note;
        $display("[TB] edge spacing=%0d class=%0d note_id=%0d expect=%0d chg=%0d",
                 last_sp, ref_class(last_sp), note_id, m_shown, note_change);
      end
      if (armed != 0 && since == TMO + 2) begin
        armed = 0;
        go_silent();
        if (m_shown != 0) exp_chg = 1;
        m_shown = 0;
        $display("[TB] timeout note_id=%0d expect=0 chg=%0d", note_id, note_change);
      end
      check("note_id", note_id, m_shown);
      check("note_valid", note_valid, (m_shown != 0) ? 1 : 0);
      check("note_change", note_change, exp_chg);
      check("half_period", half_period, m_hp_shown);
    end
  endtask

  task automatic toggle();
    tone_in = ~tone_in;
    model_edge(since);
    since = 0;
    armed = 1;
  endtask

  // Toggle so the edge lands n cycles after the previous one
  task automatic step(input int n);
    if (since < n) wait_cycles(n - since);
    toggle();
  endtask

  task automatic play(input int note, input int cnt);
    repeat (cnt) step(nominal[note]);
  endtask

  task automatic settle();
    if (since < 6) wait_cycles(6 - since);
  endtask

  task automatic expect_note(input string tag, input int v);
    settle();
    check(tag, note_id, v);
  endtask

  task automatic pulse_disable(input int cyc);
    settle();
    enable = 1'b0;
    go_silent();
    armed = 0;
    force_silent = 1;
    wait_cycles(cyc);
    enable = 1'b1;
    $display("[TB] disable for %0d cycles", cyc);
  endtask

  task automatic reset_mid();
    // Keep the input low so no spurious edge appears when the synchroniser clears
    if (tone_in) play(m_note, 1);
    settle();
    #5;
    rst = 1'b1;
    #1;
    check("rst_note_id", note_id, 0);
    check("rst_note_valid", note_valid, 0);
    check("rst_half_period", half_period, 0);
    go_silent();
    m_shown = 0;
    m_hp = 0;
    m_hp_shown = 0;
    pend = 0;
    armed = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_note_change", note_change, 0);
    rst = 1'b0;
    since = 0;
    $display("[TB] reset mid-tone");
  endtask

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, len, sp;
    rst = 1'b1;
    tone_in = 1'b0;
    enable = 1'b1;
    m_note = 0; m_shown = 0; m_hunt = 0; s_val = 0; s_len = 0; m_disc = 1;
    m_hp = 0; m_hp_shown = 0; pend = 0; since = 0; armed = 0;
    force_silent = 0; last_sp = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_note_id", note_id, 0);
    check("reset_note_valid", note_valid, 0);
    check("reset_note_change", note_change, 0);
    check("reset_half_period", half_period, 0);
    rst = 1'b0;

    // Lock on do: the first edge is discarded, the fifth locks
    play(1, 4);
    expect_note("do_before_lock", 0);
    play(1, 1);
    expect_note("do_lock", 1);
    check("do_half_period", half_period, nominal[1]);

    // sol, then la: three la edges hold sol, the fourth locks la
    play(5, 4);
    expect_note("sol_lock", 5);
    play(6, 3);
    expect_note("la_pending", 5);
    play(6, 1);
    expect_note("la_lock", 6);

    // mi with a single do2-length glitch: no change
    play(3, 4);
    expect_note("mi_lock", 3);
    step(188);
    play(3, 4);
    expect_note("mi_glitch_hold", 3);

    // do2 then silence long enough to time out
    play(8, 4);
    expect_note("do2_lock", 8);
    wait_cycles(TMO + 10 - since);
    check("timeout_note_id", note_id, 0);
    check("timeout_note_valid", note_valid, 0);
    play(8, 4);
    expect_note("relock_after_timeout_pending", 0);
    play(8, 1);
    expect_note("relock_after_timeout", 8);

    // Bin boundaries
    pulse_disable(5);
    for (int i = 0; i < 5; i++) step(352);
    expect_note("boundary_352_re", 2);
    for (int i = 0; i < 4; i++) step(353);
    expect_note("boundary_353_do", 1);
    pulse_disable(5);
    for (int i = 0; i < 6; i++) step(392);
    expect_note("boundary_392_none", 0);

    // enable low mid-lock
    play(4, 4);
    expect_note("fa_lock", 4);
    pulse_disable(7);
    play(4, 4);
    expect_note("fa_after_disable_pending", 0);
    play(4, 1);
    expect_note("fa_after_disable", 4);

    // Reset mid-lock
    reset_mid();
    play(7, 4);
    expect_note("si_after_reset_pending", 0);
    play(7, 1);
    expect_note("si_after_reset", 7);

    // Random runs of notes and out-of-range spacings
    for (int run = 0; run < 30; run++) begin
      r   = $urandom_range(0, 8);
      len = $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0) pulse_disable($urandom_range(1, 20));
      for (int j = 0; j < len; j++) begin
        if (r == 0) begin
          if ($urandom_range(0, 1) == 0) sp = $urandom_range(100, HPMIN - 1);
          else sp = $urandom_range(upper[1] + 1, 480);
        end else if (r == 8) begin
          sp = $urandom_range(HPMIN, upper[8]);
        end else begin
          sp = $urandom_range(upper[r + 1] + 1, upper[r]);
        end
        step(sp);
      end
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
